div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/alu_pkg.sv | 32 +++
 rtl/div_iter.sv | 64 ++++++
 rtl/div_unit.sv | 149 ++++++++++++++
 tb/tb_div_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider operation codes, FSM state encoding and
// operation-decoding helpers used by div_unit and div_iter.
package alu_pkg;

   localparam logic [4:0] ALU_DIV  = 5'b11000;
   localparam logic [4:0] ALU_DIVU = 5'b11001;
   localparam logic [4:0] ALU_REM  = 5'b11010;
   localparam logic [4:0] ALU_REMU = 5'b11011;

   localparam int         DIV_CNT_W = 6;
   localparam logic [5:0] DIV_ITERS = 6'd32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   function automatic logic is_div_op(input logic [4:0] sel);
      return (sel == ALU_DIV) || (sel == ALU_DIVU) ||
             (sel == ALU_REM) || (sel == ALU_REMU);
   endfunction

   function automatic logic is_signed_op(input logic [4:0] sel);
      return (sel == ALU_DIV) || (sel == ALU_REM);
   endfunction

   function automatic logic is_rem_op(input logic [4:0] sel);
      return (sel == ALU_REM) || (sel == ALU_REMU);
   endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring shift/subtract datapath: one quotient bit per step on unsigned
// magnitudes, holding remainder, quotient and the iteration counter.
module div_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done
);

   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]       shifted;
   logic [WIDTH:0]       diff;

   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      shifted = {rem_q, quo_q[WIDTH-1]};
      diff    = shifted - {1'b0, dvs_q};
      if (load) begin
         rem_d = '0;
         quo_d = dividend;
         dvs_d = divisor;
         cnt_d = '0;
      end else if (step && (cnt_q != DIV_ITERS)) begin
         // A borrow means the trial subtract failed: add the divisor back.
         rem_d = diff[WIDTH] ? (diff[WIDTH-1:0] + dvs_q) : diff[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign done      = (cnt_q == DIV_ITERS);

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider (DIV/DIVU/REM/REMU) with sign handling and a fast
// path for divide-by-zero and signed overflow. Optional FLUSH port: DIV_UNIT_FLUSH_EN.
module div_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   input  logic [4:0]       SELECT,
`ifdef DIV_UNIT_FLUSH_EN
   input  logic             FLUSH,
`endif
   output logic             BUSY,
   output logic             VALID,
   output logic [WIDTH-1:0] RESULT
);

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] fast_val_q, fast_val_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             fast_q, fast_d;
   logic             rem_op_q, rem_op_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;

   logic             flush;
   logic             legal, sgn, rem_op, div0, ovf, accept;
   logic             load, step, iter_done;
   logic [WIDTH-1:0] mag_a, mag_b, quo, rem;

`ifdef DIV_UNIT_FLUSH_EN
   assign flush = FLUSH;
`else
   assign flush = 1'b0;
`endif

   assign legal  = is_div_op(SELECT);
   assign sgn    = is_signed_op(SELECT);
   assign rem_op = is_rem_op(SELECT);
   assign mag_a  = (sgn && DATA1[WIDTH-1]) ? -DATA1 : DATA1;
   assign mag_b  = (sgn && DATA2[WIDTH-1]) ? -DATA2 : DATA2;
   assign div0   = (DATA2 == '0);
   assign ovf    = sgn && (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) && (DATA2 == '1);
   assign accept = START && legal && !fast_q && (state_q != DIV_CALC);

   div_iter #(.WIDTH(WIDTH)) u_iter (
      .clk       (CLK),
      .rst_n     (RESET),
      .load      (load),
      .step      (step),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (quo),
      .remainder (rem),
      .done      (iter_done)
   );

   // Fast-path results are staged for one cycle so they surface with the
   // same one-edge delay as a registered computation, without entering CALC.
   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      fast_val_d = fast_val_q;
      fast_d     = fast_q;
      rem_op_d   = rem_op_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      valid_d    = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      if (flush) begin
         state_d = DIV_IDLE;
         fast_d  = 1'b0;
      end else if (fast_q) begin
         result_d = fast_val_q;
         fast_d   = 1'b0;
         state_d  = DIV_DONE;
         valid_d  = 1'b1;
      end else begin
         case (state_q)
            DIV_CALC: begin
               if (iter_done) begin
                  if (rem_op_q) result_d = neg_rem_q ? -rem : rem;
                  else          result_d = neg_quo_q ? -quo : quo;
                  state_d = DIV_DONE;
                  valid_d = 1'b1;
               end else begin
                  step = 1'b1;
               end
            end
            DIV_IDLE, DIV_DONE: begin
               state_d = DIV_IDLE;
               if (accept) begin
                  if (div0) begin
                     fast_d     = 1'b1;
                     fast_val_d = rem_op ? DATA1 : '1;
                  end else if (ovf) begin
                     fast_d     = 1'b1;
                     fast_val_d = rem_op ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
                  end else begin
                     load      = 1'b1;
                     state_d   = DIV_CALC;
                     rem_op_d  = rem_op;
                     neg_quo_d = sgn && (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
                     neg_rem_d = sgn && DATA1[WIDTH-1];
                  end
               end
            end
            default: state_d = DIV_IDLE;
         endcase
      end
      busy_d = (state_d == DIV_CALC);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= DIV_IDLE;
         result_q   <= '0;
         fast_val_q <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         fast_q     <= 1'b0;
         rem_op_q   <= 1'b0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         fast_val_q <= fast_val_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         fast_q     <= fast_d;
         rem_op_q   <= rem_op_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
      end
   end

   assign BUSY   = busy_q;
   assign VALID  = valid_q;
   assign RESULT = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results and their
// due edge; a negedge monitor checks VALID/RESULT/latency and BUSY every cycle.
module tb_div_unit;

   localparam logic [4:0] OP_DIV  = 5'b11000;
   localparam logic [4:0] OP_DIVU = 5'b11001;
   localparam logic [4:0] OP_REM  = 5'b11010;
   localparam logic [4:0] OP_REMU = 5'b11011;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] data1 = '0;
   logic [31:0] data2 = '0;
   logic [4:0]  sel   = '0;
   logic        busy, valid;
   logic [31:0] result;
`ifdef DIV_UNIT_FLUSH_EN
   logic        flush = 1'b0;
`endif

   typedef struct {
      logic [31:0] res;
      int          edge_at;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errs   = 0;
   int   edge_cnt = 0;
   int   busy_from = 1;
   int   busy_to   = 0;
   int   last_k    = 0;
   logic prev_valid = 1'b0;

   div_unit #(.WIDTH(32)) dut (
      .CLK    (clk),
      .RESET  (rst_n),
      .START  (start),
      .DATA1  (data1),
      .DATA2  (data2),
      .SELECT (sel),
`ifdef DIV_UNIT_FLUSH_EN
      .FLUSH  (flush),
`endif
      .BUSY   (busy),
      .VALID  (valid),
      .RESULT (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errs++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Division defined directly from the arithmetic rules, special cases first.
   function automatic logic [31:0] refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return ((op == OP_DIV) || (op == OP_DIVU)) ? 32'hFFFF_FFFF : a;
      if (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))
         return (op == OP_DIV) ? 32'h8000_0000 : 32'h0;
      case (op)
         OP_DIV:  return sa / sb;
         OP_DIVU: return a / b;
         OP_REM:  return sa % sb;
         default: return a % b;
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      logic exp_busy;
      exp_busy = (edge_cnt >= busy_from) && (edge_cnt <= busy_to);
      checkOutput("busy", {31'b0, busy}, {31'b0, exp_busy});
      if (valid) begin
         checkOutput("valid_pulse_width", {31'b0, prev_valid}, 32'd0);
         if (exp_q.size() == 0) begin
            checkOutput("spurious_valid", {31'b0, valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("result op=%b a=%h b=%h", e.op, e.a, e.b), result, e.res);
            checkOutput($sformatf("latency op=%b a=%h b=%h", e.op, e.a, e.b), edge_cnt, e.edge_at);
         end
      end
      prev_valid <= valid;
   end

   // Drives one request; the next rising edge is the sampling edge k.
   task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_v, input bit use_exp);
      exp_t e;
      bit   fast;
      int   k;
      start = 1'b1;
      sel   = op;
      data1 = a;
      data2 = b;
      k      = edge_cnt + 1;
      last_k = k;
      if ((op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU)) begin
         fast = (b == 32'd0) ||
                (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
         e.res     = use_exp ? exp_v : refModel(op, a, b);
         e.edge_at = fast ? k + 1 : k + 33;
         e.op      = op;
         e.a       = a;
         e.b       = b;
         exp_q.push_back(e);
         if (!fast) begin
            busy_from = k;
            busy_to   = k + 32;
         end
      end
      @(posedge clk);
      #2;
      start = 1'b0;
      sel   = 5'($urandom);
      data1 = $urandom;
      data2 = $urandom;
   endtask

   task automatic waitDone();
      int t = 0;
      while ((exp_q.size() != 0) && (t < 120)) begin
         @(negedge clk);
         t++;
      end
      #1;
      checkOutput("scoreboard_drain", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic waitValid();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!valid && (t < 120));
      #1;
      checkOutput("valid_wait", {31'b0, valid}, 32'd1);
   endtask

   initial begin
      logic [4:0]  d_op  [7] = '{OP_DIV, OP_REM, OP_DIVU, OP_DIV, OP_REMU, OP_DIV, OP_REM};
      logic [31:0] d_a   [7] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd5, 32'd5,
                                 32'h8000_0000, 32'h8000_0000};
      logic [31:0] d_b   [7] = '{32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] d_exp [7] = '{32'd14, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                                 32'h8000_0000, 32'd0};
      logic [4:0]  op;
      logic [31:0] a, b;
`ifdef DIV_UNIT_FLUSH_EN
      logic [31:0] held;
`endif

      #1;
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_valid", {31'b0, valid}, 32'd0);
      checkOutput("reset_result", result, 32'd0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      $display("[TB] directed operations");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(d_op[i], d_a[i], d_b[i], d_exp[i], 1'b1);
         waitDone();
         @(posedge clk);
         #2;
      end

      $display("[TB] illegal SELECT and START during CALC");
      applyStimulus(5'b00000, 32'd100, 32'd7, 32'd0, 1'b0);
      applyStimulus(5'b11100, 32'd100, 32'd7, 32'd0, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      applyStimulus(OP_DIVU, 32'd1000, 32'd10, 32'd100, 1'b1);
      repeat (8) @(posedge clk);
      #2;
      start = 1'b1;
      sel   = OP_DIV;
      data1 = 32'd77;
      data2 = 32'd0;
      @(posedge clk);
      #2;
      start = 1'b0;
      waitDone();
      repeat (5) @(posedge clk);
      #2;

      $display("[TB] randomized operations");
      for (int i = 0; i < 40; i++) begin
         op = {3'b110, 2'($urandom_range(0, 3))};
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 15);
            3: begin a = -$urandom_range(0, 1000); b = $urandom_range(1, 20); end
            4: b = -$urandom_range(1, 20);
            default: ;
         endcase
         applyStimulus(op, a, b, 32'd0, 1'b0);
         if ($urandom_range(0, 1) == 1) begin
            waitValid();
         end else begin
            waitDone();
            @(posedge clk);
            #2;
         end
      end
      waitDone();
      @(posedge clk);
      #2;

      $display("[TB] reset during CALC");
      applyStimulus(OP_DIV, 32'h1234_5678, 32'd3, 32'd0, 1'b0);
      repeat (9) @(posedge clk);
      #2;
      rst_n   = 1'b0;
      busy_to = edge_cnt - 1;
      exp_q.delete();
      #1;
      checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("async_reset_result", result, 32'd0);
      checkOutput("async_reset_valid", {31'b0, valid}, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #2;
      applyStimulus(OP_DIV, 32'd9, 32'd3, 32'd3, 1'b1);
      waitDone();
      @(posedge clk);
      #2;

`ifdef DIV_UNIT_FLUSH_EN
      $display("[TB] flush");
      held = result;
      applyStimulus(OP_DIVU, 32'd5000, 32'd7, 32'd0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      flush   = 1'b1;
      start   = 1'b1;
      sel     = OP_REM;
      data1   = 32'd50;
      data2   = 32'd0;
      busy_to = edge_cnt;
      exp_q.delete();
      @(posedge clk);
      #2;
      flush = 1'b0;
      start = 1'b0;
      checkOutput("flush_busy", {31'b0, busy}, 32'd0);
      checkOutput("flush_result_held", result, held);
      repeat (40) @(posedge clk);
      #2;
      flush = 1'b1;
      start = 1'b1;
      sel   = OP_DIV;
      data1 = 32'd8;
      data2 = 32'd0;
      @(posedge clk);
      #2;
      flush = 1'b0;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      checkOutput("flush_start_ignored", result, held);
      applyStimulus(OP_REMU, 32'd5000, 32'd7, 32'd2, 1'b1);
      waitDone();
      @(posedge clk);
      #2;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
      $finish;
   end

endmodule
